// File: rtl/rename_unit_pkg.sv
// rtl/rename_unit_pkg.sv - shared constants and types for the rename stage
package rename_unit_pkg;
    localparam int RN_ARCH_REGS = 32;
    localparam int RN_NUM_PREG  = 64;
    localparam int RN_PREG_W    = $clog2(RN_NUM_PREG);
    localparam int RN_FL_DEPTH  = RN_NUM_PREG - RN_ARCH_REGS;

    typedef logic [4:0] areg_t;
endpackage

// File: rtl/rn_freelist.sv
// rtl/rn_freelist.sv - circular free list with speculative head, committed head and tail
module rn_freelist
    import rename_unit_pkg::*;
#(
    parameter int PREG_W = RN_PREG_W,
    parameter int DEPTH  = RN_FL_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop,
    input  logic              push,
    input  logic [PREG_W-1:0] push_data,
    input  logic              restore,
    output logic [PREG_W-1:0] head_data,
    output logic              empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head, arch_head, tail, arch_head_nxt;
    logic              full;

    // Wrap at DEPTH rather than at the binary boundary so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
            return {~p[PTR_W-1], {IDX_W{1'b0}}};
        else
            return p + PTR_W'(1);
    endfunction

    assign head_data     = mem[head[IDX_W-1:0]];
    assign empty         = (head == tail);
    assign full          = (head[PTR_W-1] != tail[PTR_W-1]) &&
                           (head[IDX_W-1:0] == tail[IDX_W-1:0]);
    assign arch_head_nxt = push ? ptr_inc(arch_head) : arch_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= PREG_W'(RN_ARCH_REGS + i);
            head      <= '0;
            arch_head <= '0;
            tail      <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            if (push) begin
                mem[tail[IDX_W-1:0]] <= push_data;
                tail                 <= ptr_inc(tail);
            end
            arch_head <= arch_head_nxt;
            if (restore)
                head <= arch_head_nxt;
            else if (pop)
                head <= ptr_inc(head);
        end
    end

    always @(posedge clk) begin
        if (!rst)
            assert (!(push && full && !pop));
    end
endmodule

// File: rtl/rename_unit.sv
// rtl/rename_unit.sv - register rename: speculative/architectural RATs, free list, ready table
module rename_unit
    import rename_unit_pkg::*;
#(
    parameter int NUM_PREG = RN_NUM_PREG,
    parameter int PREG_W   = RN_PREG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_RN,
    input  logic              RegWrite_RN,
    input  logic              ROBWrite_en_RN,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [PREG_W-1:0] wb_prd,
    input  logic              cm_en,
    input  areg_t             cm_rd,
    input  logic [PREG_W-1:0] cm_prd,
    input  logic [PREG_W-1:0] cm_old_prd,
    output logic [PREG_W-1:0] prs1,
    output logic [PREG_W-1:0] prs2,
    output logic              rs1_rdy,
    output logic              rs2_rdy,
    output logic [PREG_W-1:0] prd,
    output logic [PREG_W-1:0] old_prd,
    output logic              rn_fire,
    output logic              stall_RN
);
    logic [PREG_W-1:0] spec_rat     [RN_ARCH_REGS];
    logic [PREG_W-1:0] arch_rat     [RN_ARCH_REGS];
    logic [PREG_W-1:0] arch_rat_nxt [RN_ARCH_REGS];
    logic [NUM_PREG-1:0] ready;

    areg_t             rs1, rs2, rd;
    logic              alloc, pop, fl_empty;
    logic [PREG_W-1:0] fl_head;
    logic              unused_inst;

    assign rs1         = inst_RN[19:15];
    assign rs2         = inst_RN[24:20];
    assign rd          = inst_RN[11:7];
    assign unused_inst = ^{inst_RN[31:25], inst_RN[14:12], inst_RN[6:0]};

    assign alloc    = ROBWrite_en_RN & RegWrite_RN & (rd != 5'd0);
    assign stall_RN = ROBWrite_en_RN & (stall_in | (alloc & fl_empty));
    assign rn_fire  = ROBWrite_en_RN & ~stall_RN & ~flush;
    assign pop      = rn_fire & alloc;

    // Sources see the pre-update map, so rs==rd picks up the older producer.
    assign prs1    = spec_rat[rs1];
    assign prs2    = spec_rat[rs2];
    assign rs1_rdy = (rs1 == 5'd0) | ready[prs1] | (wb_en & (wb_prd == prs1));
    assign rs2_rdy = (rs2 == 5'd0) | ready[prs2] | (wb_en & (wb_prd == prs2));
    assign prd     = pop ? fl_head : '0;
    assign old_prd = pop ? spec_rat[rd] : '0;

    always_comb begin
        for (int i = 0; i < RN_ARCH_REGS; i++)
            arch_rat_nxt[i] = arch_rat[i];
        if (cm_en && cm_rd != 5'd0)
            arch_rat_nxt[cm_rd] = cm_prd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RN_ARCH_REGS; i++) begin
                spec_rat[i] <= PREG_W'(i);
                arch_rat[i] <= PREG_W'(i);
            end
            ready <= '1;
        end else begin
            arch_rat <= arch_rat_nxt;
            if (flush) begin
                spec_rat <= arch_rat_nxt;
                ready    <= '1;
            end else begin
                if (pop) begin
                    spec_rat[rd]   <= fl_head;
                    ready[fl_head] <= 1'b0;
                end
                if (wb_en)
                    ready[wb_prd] <= 1'b1;
            end
        end
    end

    rn_freelist #(
        .PREG_W (PREG_W),
        .DEPTH  (NUM_PREG - RN_ARCH_REGS)
    ) u_freelist (
        .clk       (clk),
        .rst       (rst),
        .pop       (pop),
        .push      (cm_en),
        .push_data (cm_old_prd),
        .restore   (flush),
        .head_data (fl_head),
        .empty     (fl_empty)
    );
endmodule

// File: tb/tb_rename_unit.sv
// tb/tb_rename_unit.sv - self-checking bench for rename_unit against a queue-based model
module tb_rename_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_RN;
    logic        RegWrite_RN, ROBWrite_en_RN, stall_in, flush, wb_en, cm_en;
    logic [5:0]  wb_prd, cm_prd, cm_old_prd;
    logic [4:0]  cm_rd;
    logic [5:0]  prs1, prs2, prd, old_prd;
    logic        rs1_rdy, rs2_rdy, rn_fire, stall_RN;

    int total = 0;
    int bad   = 0;

    rename_unit dut (
        .clk(clk), .rst(rst), .inst_RN(inst_RN), .RegWrite_RN(RegWrite_RN),
        .ROBWrite_en_RN(ROBWrite_en_RN), .stall_in(stall_in), .flush(flush),
        .wb_en(wb_en), .wb_prd(wb_prd), .cm_en(cm_en), .cm_rd(cm_rd),
        .cm_prd(cm_prd), .cm_old_prd(cm_old_prd), .prs1(prs1), .prs2(prs2),
        .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy), .prd(prd), .old_prd(old_prd),
        .rn_fire(rn_fire), .stall_RN(stall_RN)
    );

    always #5 clk = ~clk;

    // Model: maps as arrays, free list and in-flight allocations as queues.
    int         smap [32];
    int         amap [32];
    bit         mrdy [64];
    logic [5:0] fl [$];
    logic [5:0] infl [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [4:0] d, a, b;
        d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
        return {7'd0, b, a, 3'd0, d, 7'h33};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin smap[i] = i; amap[i] = i; end
        for (int i = 0; i < 64; i++) mrdy[i] = 1'b1;
        fl.delete(); infl.delete();
        for (int i = 32; i < 64; i++) fl.push_back(6'(i));
    endtask

    function automatic bit m_alloc();
        return ROBWrite_en_RN && RegWrite_RN && inst_RN[11:7] != 0;
    endfunction
    function automatic bit m_stall();
        return ROBWrite_en_RN && (stall_in || (m_alloc() && fl.size() == 0));
    endfunction
    function automatic bit m_fire();
        return ROBWrite_en_RN && !m_stall() && !flush;
    endfunction
    function automatic bit m_rdy(input int rs);
        int p;
        p = smap[rs];
        return rs == 0 || mrdy[p] || (wb_en && int'(wb_prd) == p);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            bit         do_pop;
            int         rd;
            logic [5:0] p;
            do_pop = m_fire() && m_alloc();
            rd     = int'(inst_RN[11:7]);
            if (cm_en) begin
                if (cm_rd != 0) amap[cm_rd] = int'(cm_prd);
                if (infl.size() > 0) void'(infl.pop_front());
                fl.push_back(cm_old_prd);
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) smap[i] = amap[i];
                fl = {infl, fl};
                infl.delete();
                for (int i = 0; i < 64; i++) mrdy[i] = 1'b1;
            end else begin
                if (do_pop) begin
                    p = fl.pop_front();
                    infl.push_back(p);
                    mrdy[p] = 1'b0;
                    smap[rd] = int'(p);
                end
                if (wb_en) mrdy[wb_prd] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit fire, al;
            fire = m_fire();
            al   = m_alloc();
            check("cmp_stall", stall_RN, m_stall());
            check("cmp_fire", rn_fire, fire);
            check("cmp_prs1", prs1, smap[inst_RN[19:15]]);
            check("cmp_prs2", prs2, smap[inst_RN[24:20]]);
            check("cmp_rdy1", rs1_rdy, m_rdy(int'(inst_RN[19:15])));
            check("cmp_rdy2", rs2_rdy, m_rdy(int'(inst_RN[24:20])));
            check("cmp_prd", prd, (fire && al) ? fl[0] : 6'd0);
            check("cmp_old", old_prd, (fire && al) ? 6'(smap[inst_RN[11:7]]) : 6'd0);
        end
    end

    task automatic idle();
        inst_RN = 32'd0; RegWrite_RN = 0; ROBWrite_en_RN = 0; stall_in = 0; flush = 0;
        wb_en = 0; wb_prd = 0; cm_en = 0; cm_rd = 0; cm_prd = 0; cm_old_prd = 0;
    endtask
    task automatic ren(input int rd, input int rs1, input int rs2);
        inst_RN = mk(rd, rs1, rs2); RegWrite_RN = 1; ROBWrite_en_RN = 1;
    endtask
    task automatic settle(); @(negedge clk); #1; endtask
    task automatic tick();   @(posedge clk); #1; endtask
    task automatic do_reset();
        @(posedge clk); #3 rst = 1; #4 rst = 0; tick();
    endtask

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        idle();
        #2 rst = 1;
        #10 rst = 0;
        tick();
        settle();
        check("rst_fire", rn_fire, 0);
        check("rst_prd", prd, 0);
        check("rst_stall", stall_RN, 0);
        tick();

        // add x5,x1,x2 then x6 <- x5
        ren(5, 1, 2); settle();
        check("a_prs1", prs1, 1); check("a_prs2", prs2, 2);
        check("a_rdy1", rs1_rdy, 1); check("a_rdy2", rs2_rdy, 1);
        check("a_prd", prd, 32); check("a_old", old_prd, 5); check("a_fire", rn_fire, 1);
        tick();
        ren(6, 5, 5); settle();
        check("a2_prs1", prs1, 32); check("a2_rdy1", rs1_rdy, 0);
        check("a2_prd", prd, 33); check("a2_old", old_prd, 6);
        tick(); idle();

        // add x5,x5,x5 twice, second with writeback bypass of p32
        do_reset();
        ren(5, 5, 5); settle();
        check("b_prs1", prs1, 5); check("b_prd", prd, 32); check("b_old", old_prd, 5);
        tick();
        wb_en = 1; wb_prd = 32; settle();
        check("b2_prs1", prs1, 32); check("b2_prs2", prs2, 32);
        check("b2_rdy1", rs1_rdy, 1); check("b2_rdy2", rs2_rdy, 1);
        check("b2_prd", prd, 33); check("b2_old", old_prd, 32);
        tick(); idle();

        // exhaust the free list, then free p5 via commit
        do_reset();
        for (int i = 0; i < 32; i++) begin
            ren(((i + 4) % 31) + 1, 0, 0); settle();
            check("c_fire", rn_fire, 1); check("c_prd", prd, 32 + i);
            tick();
        end
        ren(7, 1, 1); settle();
        check("c_stall", stall_RN, 1); check("c_nofire", rn_fire, 0); check("c_prd0", prd, 0);
        tick();
        cm_en = 1; cm_rd = 5; cm_prd = 32; cm_old_prd = 5; settle();
        check("c_stall_push", stall_RN, 1);
        tick();
        cm_en = 0; settle();
        check("c_fire_after", rn_fire, 1); check("c_prd_wrap", prd, 5);
        tick(); idle();

        // x3,x4 renamed, commit x3, flush, rename again
        do_reset();
        ren(3, 0, 0); tick();
        ren(4, 0, 0); tick();
        idle(); cm_en = 1; cm_rd = 3; cm_prd = 32; cm_old_prd = 3; tick();
        idle(); flush = 1; ren(9, 0, 0); settle();
        check("d_flush_fire", rn_fire, 0); check("d_flush_prd", prd, 0);
        tick();
        flush = 0; ren(6, 3, 4); settle();
        check("d_prs1", prs1, 32); check("d_prs2", prs2, 4);
        check("d_rdy1", rs1_rdy, 1); check("d_prd", prd, 33); check("d_old", old_prd, 6);
        tick();

        // x0 destination and downstream stall
        ren(0, 1, 2); settle();
        check("e_x0_fire", rn_fire, 1); check("e_x0_prd", prd, 0); check("e_x0_old", old_prd, 0);
        tick();
        ren(8, 0, 0); stall_in = 1; settle();
        check("e_stall", stall_RN, 1); check("e_stall_fire", rn_fire, 0); check("e_stall_prd", prd, 0);
        tick();
        stall_in = 0; settle();
        check("e_prd_next", prd, 34);
        tick();

        // asynchronous reset between edges
        ren(10, 5, 0);
        @(posedge clk); #3 rst = 1; #1;
        check("f_prs1", prs1, 5); check("f_rdy1", rs1_rdy, 1);
        check("f_prd", prd, 32); check("f_old", old_prd, 10);
        @(negedge clk); rst = 0;
        tick(); idle(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
